// File: rtl/rv32i_types_pkg.sv
// Shared RV32 register-file types and constants.
// Default-configuration word/select types plus RV32I/RV32E register counts.
package rv32i_types_pkg;

    localparam int RV32I_NUM_REGS = 32;
    localparam int RV32E_NUM_REGS = 16;
    localparam int XLEN           = 32;

    typedef logic [$clog2(RV32I_NUM_REGS)-1:0] regsel_t;
    typedef logic [XLEN-1:0]                   word_t;

    // Largest value a pending counter of width w can hold.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/rv32_mp_reg_file_if.sv
// Bundle of register-file ports for decode, writeback and issue.
// Modports: rf (the file), cu (operand fetch), wb (writeback), issue (reservation).
interface rv32_mp_reg_file_if #(
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 1,
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = rv32i_types_pkg::RV32I_NUM_REGS,
    parameter int SEL_W     = $clog2(NUM_REGS)
);

    logic [NUM_READ*SEL_W-1:0]   rs;
    logic [NUM_READ*DATA_W-1:0]  rs_data;
    logic [NUM_READ-1:0]         rs_busy;
    logic [NUM_WRITE-1:0]        wen;
    logic [NUM_WRITE*SEL_W-1:0]  rd;
    logic [NUM_WRITE*DATA_W-1:0] w_data;
    logic                        rsv_valid;
    logic [SEL_W-1:0]            rsv_rd;
    logic                        rsv_ready;

    modport rf (
        input  rs, wen, rd, w_data, rsv_valid, rsv_rd,
        output rs_data, rs_busy, rsv_ready
    );

    modport cu (
        output rs,
        input  rs_data, rs_busy
    );

    modport wb (
        output wen, rd, w_data
    );

    modport issue (
        output rsv_valid, rsv_rd,
        input  rsv_ready
    );

endinterface

// File: rtl/rv32_mp_reg_file_pending_counter.sv
// rf_pending_counter: one register's in-flight write count.
// Adds inc, subtracts dec, clamps to [0, max] so it can never wrap.
module rf_pending_counter #(
    parameter int CNT_W = 2,
    parameter int DEC_W = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec,
    output logic [CNT_W-1:0] cnt
);

    localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;
    localparam logic [SUM_W-1:0] MAX_W = SUM_W'((1 << CNT_W) - 1);

    logic [SUM_W-1:0] up;
    logic [SUM_W-1:0] dn;
    logic [CNT_W-1:0] cnt_d;

    // Net change +inc-dec with saturation at both ends.
    always_comb begin
        up    = SUM_W'(cnt) + SUM_W'(inc);
        dn    = SUM_W'(dec);
        cnt_d = '0;
        if (up <= dn) begin
            cnt_d = '0;
        end else if ((up - dn) > MAX_W) begin
            cnt_d = '1;
        end else begin
            cnt_d = CNT_W'(up - dn);
        end
    end

    // Count register, cleared immediately on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/rv32_mp_reg_file.sv
// Multi-port integer register file with per-register pending-write scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writes to read ports and busy flags.
module rv32_mp_reg_file
    import rv32i_types_pkg::*;
#(
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 1,
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = RV32I_NUM_REGS,
    parameter int CNT_W     = 2,
    parameter int SEL_W     = $clog2(NUM_REGS)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_READ*SEL_W-1:0]   rs,
    output logic [NUM_READ*DATA_W-1:0]  rs_data,
    output logic [NUM_READ-1:0]         rs_busy,
    input  logic [NUM_WRITE-1:0]        wen,
    input  logic [NUM_WRITE*SEL_W-1:0]  rd,
    input  logic [NUM_WRITE*DATA_W-1:0] w_data,
    input  logic                        rsv_valid,
    input  logic [SEL_W-1:0]            rsv_rd,
    output logic                        rsv_ready
);

    localparam int DEC_W = $clog2(NUM_WRITE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt    [NUM_REGS];
    logic [DEC_W-1:0]  hits   [NUM_REGS];
    logic              rsv_acc;

    // Number of enabled write ports aimed at each register this cycle.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            hits[r] = '0;
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (wen[p] && rd[p*SEL_W +: SEL_W] == SEL_W'(r)) begin
                    hits[r] = hits[r] + DEC_W'(1);
                end
            end
        end
    end

    // A full counter refuses new reservations unless a write drains it now.
    always_comb begin
        rsv_ready = 1'b1;
        if (!RST && cnt[rsv_rd] == CNT_MAX && hits[rsv_rd] == '0) begin
            rsv_ready = 1'b0;
        end
        rsv_acc = rsv_valid && rsv_ready && !RST && (rsv_rd != '0);
    end

    // Storage; later ports overwrite earlier ones, x0 is never written.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                for (int p = 0; p < NUM_WRITE; p++) begin
                    if (wen[p] && rd[p*SEL_W +: SEL_W] == SEL_W'(r)) begin
                        regs_q[r] <= w_data[p*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        if (r == 0) begin : g_zero
            assign cnt[r] = '0;
        end else begin : g_ctr
            rf_pending_counter #(
                .CNT_W (CNT_W),
                .DEC_W (DEC_W)
            ) u_cnt (
                .CLK (CLK),
                .RST (RST),
                .inc (rsv_acc && (rsv_rd == SEL_W'(r))),
                .dec (hits[r]),
                .cnt (cnt[r])
            );
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] rdata;
        logic              rbusy;

        assign sel = rs[i*SEL_W +: SEL_W];

        // Operand fetch and readiness for one read port.
        always_comb begin
            rdata = regs_q[sel];
            rbusy = (cnt[sel] != '0);
`ifdef RF_BYPASS_EN
            for (int p = 0; p < NUM_WRITE; p++) begin
                if (sel != '0 && wen[p] &&
                    rd[p*SEL_W +: SEL_W] == sel) begin
                    rdata = w_data[p*DATA_W +: DATA_W];
                end
            end
            rbusy = (int'(cnt[sel]) > int'(hits[sel]));
`endif
            if (RST) begin
                rdata = '0;
                rbusy = 1'b0;
            end
        end

        assign rs_data[i*DATA_W +: DATA_W] = rdata;
        assign rs_busy[i]                  = rbusy;
    end

endmodule

// File: tb/tb_rv32_mp_reg_file.sv
// Self-checking bench for rv32_mp_reg_file (two read, two write ports).
// Expectations cover both RF_BYPASS_EN builds.
module tb_rv32_mp_reg_file;
    import rv32i_types_pkg::*;

    localparam int NR   = 2;
    localparam int NW   = 2;
    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int CW   = 2;
    localparam int SW   = 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    rv32_mp_reg_file_if #(
        .NUM_READ (NR), .NUM_WRITE (NW), .DATA_W (DW),
        .NUM_REGS (NREG), .SEL_W (SW)
    ) bus ();

    rv32_mp_reg_file #(
        .NUM_READ (NR), .NUM_WRITE (NW), .DATA_W (DW),
        .NUM_REGS (NREG), .CNT_W (CW), .SEL_W (SW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rs        (bus.rs),
        .rs_data   (bus.rs_data),
        .rs_busy   (bus.rs_busy),
        .wen       (bus.wen),
        .rd        (bus.rd),
        .w_data    (bus.w_data),
        .rsv_valid (bus.rsv_valid),
        .rsv_rd    (bus.rsv_rd),
        .rsv_ready (bus.rsv_ready)
    );

    typedef struct {
        logic [1:0] wen;
        regsel_t    rd0;
        word_t      wd0;
        regsel_t    rd1;
        word_t      wd1;
        logic       rv;
        regsel_t    rr;
        regsel_t    rs0;
        regsel_t    rs1;
        word_t      d0;
        word_t      d1;
        logic [1:0] bz;
        logic       rdy;
        word_t      bd0;
        word_t      bd1;
        logic [1:0] bbz;
    } vec_t;

    typedef struct {
        word_t      d0;
        word_t      d1;
        logic [1:0] bz;
        logic       rdy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t v(
        input logic [1:0] wen, input int rd0, input word_t wd0,
        input int rd1, input word_t wd1,
        input logic rv, input int rr, input int rs0, input int rs1,
        input word_t d0, input word_t d1, input logic [1:0] bz,
        input logic rdy,
        input word_t bd0, input word_t bd1, input logic [1:0] bbz);
        vec_t t;
        t.wen = wen;
        t.rd0 = regsel_t'(rd0);
        t.wd0 = wd0;
        t.rd1 = regsel_t'(rd1);
        t.wd1 = wd1;
        t.rv  = rv;
        t.rr  = regsel_t'(rr);
        t.rs0 = regsel_t'(rs0);
        t.rs1 = regsel_t'(rs1);
        t.d0  = d0;
        t.d1  = d1;
        t.bz  = bz;
        t.rdy = rdy;
        t.bd0 = bd0;
        t.bd1 = bd1;
        t.bbz = bbz;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        bus.wen       = t.wen;
        bus.rd        = {t.rd1, t.rd0};
        bus.w_data    = {t.wd1, t.wd0};
        bus.rsv_valid = t.rv;
        bus.rsv_rd    = t.rr;
        bus.rs        = {t.rs1, t.rs0};
    endtask

    task automatic push_exp(input vec_t t);
        exp_t e;
`ifdef RF_BYPASS_EN
        e.d0 = t.bd0;
        e.d1 = t.bd1;
        e.bz = t.bbz;
`else
        e.d0 = t.d0;
        e.d1 = t.d1;
        e.bz = t.bz;
`endif
        e.rdy = t.rdy;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic cmp(input string nm);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            checks--;
            e = sb.pop_front();
            chk({nm, " d0"}, bus.rs_data[31:0], e.d0);
            chk({nm, " d1"}, bus.rs_data[63:32], e.d1);
            chk({nm, " busy"}, 32'(bus.rs_busy), 32'(e.bz));
            chk({nm, " ready"}, 32'(bus.rsv_ready), 32'(e.rdy));
        end
    endtask

    task automatic step(input vec_t t, input string nm);
        @(negedge CLK);
        drive(t);
        push_exp(t);
        #2;
        cmp(nm);
    endtask

    vec_t z;
    vec_t m;

    initial begin
        z = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 5, 31,
                        0, 0, 2'b00, 1, 0, 0, 2'b00));
        tbl.push_back(v(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 3, 0,
                        0, 0, 2'b00, 1, 32'hDEADBEEF, 0, 2'b00));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 3, 0,
                        32'hDEADBEEF, 0, 2'b00, 1,
                        32'hDEADBEEF, 0, 2'b00));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 3,
                        0, 32'hDEADBEEF, 2'b00, 1,
                        0, 32'hDEADBEEF, 2'b00));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 7, 7, 0,
                        0, 0, 2'b00, 1, 0, 0, 2'b00));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 7, 7, 0,
                        0, 0, 2'b01, 1, 0, 0, 2'b01));
        tbl.push_back(v(1, 7, 32'h55, 0, 0, 0, 7, 7, 0,
                        0, 0, 2'b01, 1, 32'h55, 0, 2'b00));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 7, 7, 0,
                        32'h55, 0, 2'b00, 1, 32'h55, 0, 2'b00));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 9, 9, 0,
                        0, 0, 2'b00, 1, 0, 0, 2'b00));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 9, 9, 0,
                        0, 0, 2'b01, 1, 0, 0, 2'b01));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 9, 9, 0,
                        0, 0, 2'b01, 1, 0, 0, 2'b01));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 9, 9, 0,
                        0, 0, 2'b01, 0, 0, 0, 2'b01));
        tbl.push_back(v(2, 0, 0, 9, 32'h77, 1, 9, 9, 0,
                        0, 0, 2'b01, 1, 32'h77, 0, 2'b01));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 9, 9, 0,
                        32'h77, 0, 2'b01, 0, 32'h77, 0, 2'b01));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 9, 9, 0,
                        32'h77, 0, 2'b01, 0, 32'h77, 0, 2'b01));
        tbl.push_back(v(3, 9, 1, 9, 2, 0, 9, 9, 0,
                        32'h77, 0, 2'b01, 1, 2, 0, 2'b01));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 4, 9, 4,
                        2, 0, 2'b01, 1, 2, 0, 2'b01));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 4, 9, 4,
                        2, 0, 2'b11, 1, 2, 0, 2'b11));
        tbl.push_back(v(3, 4, 32'h11, 4, 32'h22, 0, 4, 4, 4,
                        0, 0, 2'b11, 1, 32'h22, 32'h22, 2'b00));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 4, 9,
                        32'h22, 2, 2'b10, 1, 32'h22, 2, 2'b10));
        tbl.push_back(v(3, 5, 32'hAB, 9, 3, 0, 0, 5, 9,
                        0, 2, 2'b10, 1, 32'hAB, 3, 2'b00));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 5, 9,
                        32'hAB, 3, 2'b00, 1, 32'hAB, 3, 2'b00));
        tbl.push_back(v(1, 9, 32'h44, 0, 0, 0, 0, 0, 9,
                        0, 3, 2'b00, 1, 0, 32'h44, 2'b00));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 9,
                        0, 32'h44, 2'b00, 1, 0, 32'h44, 2'b00));

        // Reset state, including a write held against reset.
        m = v(1, 5, 32'h1234, 0, 0, 1, 5, 5, 31,
              0, 0, 2'b00, 1, 0, 0, 2'b00);
        drive(m);
        #12;
        push_exp(m);
        cmp("reset");
        @(negedge CLK);
        RST = 1'b0;
        drive(z);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("row%0d", i));
        end

        // x2 holds 0x99 with two writes pending, then reset mid-cycle.
        step(v(1, 2, 32'h99, 0, 0, 0, 0, 2, 0,
               0, 0, 2'b00, 1, 32'h99, 0, 2'b00), "x2 wr");
        step(v(0, 0, 0, 0, 0, 1, 2, 2, 0,
               32'h99, 0, 2'b00, 1, 32'h99, 0, 2'b00), "x2 rsv1");
        step(v(0, 0, 0, 0, 0, 1, 2, 2, 0,
               32'h99, 0, 2'b01, 1, 32'h99, 0, 2'b01), "x2 rsv2");
        m = v(1, 2, 32'h5, 0, 0, 1, 2, 2, 3,
              32'h99, 32'hDEADBEEF, 2'b01, 1,
              32'h5, 32'hDEADBEEF, 2'b01);
        step(m, "pre rst");
        #1;
        RST = 1'b1;
        #1;
        m = v(1, 2, 32'h5, 0, 0, 1, 2, 2, 3,
              0, 0, 2'b00, 1, 0, 0, 2'b00);
        push_exp(m);
        cmp("async rst");
        @(posedge CLK);
        #2;
        push_exp(m);
        cmp("in rst");
        @(negedge CLK);
        RST = 1'b0;
        m = v(0, 0, 0, 0, 0, 0, 2, 2, 3,
              0, 0, 2'b00, 1, 0, 0, 2'b00);
        drive(m);
        #2;
        push_exp(m);
        cmp("post rst");
        step(m, "post rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
